crossbar_scheduler: RTL and testbench

- Sequencing controller for the 4x4 memory-module-to-CPU crossbar.
- The crossbar connects one memory module (MM) to one CPU per cycle.
- This block collects burst requests from the 4 CPUs, arbitrates round-robin and holds the grant for the requested burst length.
- It drives the crossbar's MM-scheduler and per-MM select inputs as registered signals, plus a per-CPU grant/valid strobe.

---
 rtl/crossbar_scheduler_pkg.sv | 16 +
 rtl/crossbar_scheduler_if.sv | 41 ++++
 rtl/crossbar_scheduler_rr_arbiter4.sv | 36 +++
 rtl/crossbar_scheduler.sv | 146 ++++++++++++++
 tb/tb_crossbar_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crossbar_scheduler_pkg.sv
// Shared definitions for the crossbar scheduler.
//   sched_state_e : FSM state encoding (IDLE, BURST)
//   N_CPU / N_MM  : number of requesting CPUs and memory modules
//   IDX_W         : width of a CPU or MM index
package crossbar_scheduler_pkg;

    localparam int N_CPU = 4;
    localparam int N_MM  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

endpackage

// File: rtl/crossbar_scheduler_if.sv
// Bundle of the request and crossbar-control signals of the scheduler.
//   cpu_req/cpu_mm/cpu_len/mm_enable : request side (driven by the CPUs)
//   cpu_gnt, xbar_*, busy, beat_left : scheduler outputs (all registered)
//
// Handshake: CPU i raises cpu_req[i] and keeps it high for the whole burst.
// cpu_gnt[i] high means CPU i owns the crossbar; a beat moves on every cycle
// xbar_valid is high. Dropping cpu_req[i] while granted aborts the burst at
// the next edge. cpu_mm/cpu_len are only looked at on the grant cycle.
interface crossbar_scheduler_if #(
    parameter int LEN_W = 4
);
    import crossbar_scheduler_pkg::*;

    logic [N_CPU-1:0]         cpu_req;
    logic [N_CPU*IDX_W-1:0]   cpu_mm;
    logic [N_CPU*LEN_W-1:0]   cpu_len;
    logic [N_MM-1:0]          mm_enable;

    logic [N_CPU-1:0]         cpu_gnt;
    logic [IDX_W-1:0]         xbar_scheduler;
    logic [IDX_W-1:0]         xbar_select_0;
    logic [IDX_W-1:0]         xbar_select_1;
    logic [IDX_W-1:0]         xbar_select_2;
    logic [IDX_W-1:0]         xbar_select_3;
    logic                     xbar_valid;
    logic                     busy;
    logic [LEN_W-1:0]         beat_left;

    modport master (
        output cpu_req, cpu_mm, cpu_len, mm_enable,
        input  cpu_gnt, xbar_scheduler, xbar_select_0, xbar_select_1,
               xbar_select_2, xbar_select_3, xbar_valid, busy, beat_left
    );

    modport slave (
        input  cpu_req, cpu_mm, cpu_len, mm_enable,
        output cpu_gnt, xbar_scheduler, xbar_select_0, xbar_select_1,
               xbar_select_2, xbar_select_3, xbar_valid, busy, beat_left
    );

endinterface

// File: rtl/crossbar_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter.
//   req_i : request vector
//   ptr_i : highest-priority index; scan order ptr, ptr+1, ... (mod 4)
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the winner (0 when no request)
//   any_o : at least one request present
module rr_arbiter4
    import crossbar_scheduler_pkg::*;
(
    input  logic [N_CPU-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_CPU-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest position back to ptr_i so that the candidate
    // closest to the pointer is the last one written and therefore wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = N_CPU - 1; k >= 0; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

    assign gnt_o = any_o ? (N_CPU'(1) << idx_o) : '0;

endmodule

// File: rtl/crossbar_scheduler.sv
// Burst scheduler for the 4x4 MM-to-CPU crossbar. Arbitrates the four CPU
// burst requests round-robin and holds the crossbar route for len+1 beats.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request inputs and registered crossbar/grant outputs
//   state_o    : current FSM state, for observation
module crossbar_scheduler
    import crossbar_scheduler_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crossbar_scheduler_if.slave  bus,
    output sched_state_e         state_o
);

    logic [IDX_W-1:0] mm_of  [N_CPU];
    logic [LEN_W-1:0] len_of [N_CPU];
    logic [N_CPU-1:0] elig;

    logic [N_CPU-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    sched_state_e     state_q, state_d;
    logic [N_CPU-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] sched_q, sched_d;
    logic [IDX_W-1:0] sel_q [N_MM];
    logic [IDX_W-1:0] sel_d [N_MM];
    logic             valid_q, valid_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] cur_q, cur_d;   // CPU that owns the current burst

    logic             abort;
    logic             load;
    logic             clear;

    // A request only competes if its target MM is currently enabled.
    always_comb begin
        for (int i = 0; i < N_CPU; i++) begin
            mm_of[i]  = bus.cpu_mm[i*IDX_W +: IDX_W];
            len_of[i] = bus.cpu_len[i*LEN_W +: LEN_W];
            elig[i]   = bus.cpu_req[i] & bus.mm_enable[mm_of[i]];
        end
    end

    rr_arbiter4 u_arb (
        .req_i (elig),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign abort = !bus.cpu_req[cur_q] || !bus.mm_enable[sched_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sched_d = sched_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        cur_d   = cur_q;
        load    = 1'b0;
        clear   = 1'b0;

        case (state_q)
            IDLE: load = arb_any;
            BURST: begin
                // An abort never regrants in the same cycle; the next grant
                // is decided from IDLE.
                if (abort) begin
                    clear = 1'b1;
                end else if (beat_q != '0) begin
                    beat_d = beat_q - LEN_W'(1);
                end else if (arb_any) begin
                    load = 1'b1;
                end else begin
                    clear = 1'b1;
                end
            end
            default: clear = 1'b1;
        endcase

        if (clear) begin
            state_d = IDLE;
            gnt_d   = '0;
            sched_d = '0;
            sel_d   = '{default: '0};
            valid_d = 1'b0;
            beat_d  = '0;
        end

        // mm/len are captured here only; later changes do not affect the burst.
        // The pointer moves past the winner at grant time, so an aborted
        // burst still yields priority to the next CPU.
        if (load) begin
            state_d               = BURST;
            gnt_d                 = arb_gnt;
            sched_d               = mm_of[arb_idx];
            sel_d                 = '{default: '0};
            sel_d[mm_of[arb_idx]] = arb_idx;
            valid_d               = 1'b1;
            beat_d                = len_of[arb_idx];
            rr_d                  = arb_idx + IDX_W'(1);
            cur_d                 = arb_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sched_q <= '0;
            sel_q   <= '{default: '0};
            valid_q <= 1'b0;
            beat_q  <= '0;
            rr_q    <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sched_q <= sched_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
            rr_q    <= rr_d;
            cur_q   <= cur_d;
        end
    end

    assign bus.cpu_gnt        = gnt_q;
    assign bus.xbar_scheduler = sched_q;
    assign bus.xbar_select_0  = sel_q[0];
    assign bus.xbar_select_1  = sel_q[1];
    assign bus.xbar_select_2  = sel_q[2];
    assign bus.xbar_select_3  = sel_q[3];
    assign bus.xbar_valid     = valid_q;
    assign bus.busy           = (state_q == BURST);
    assign bus.beat_left      = beat_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_crossbar_scheduler.sv
module tb_crossbar_scheduler;
    import crossbar_scheduler_pkg::*;

    localparam int LEN_W = 4;
    localparam int W     = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    crossbar_scheduler_if #(.LEN_W(LEN_W)) bus();
    sched_state_e state_o;

    crossbar_scheduler #(.LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    bit m_busy;
    int m_cpu, m_mm, m_left, m_ptr;

    function automatic int mm_of(int i);
        return int'((bus.cpu_mm >> (2 * i)) & 8'h3);
    endfunction

    function automatic int len_of(int i);
        return int'((bus.cpu_len >> (4 * i)) & 16'hF);
    endfunction

    function automatic int pick(logic [3:0] e, int p);
        for (int k = 0; k < 4; k++) begin
            if (e[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_cpu = 0; m_mm = 0; m_left = 0; m_ptr = 0;
    endtask

    task automatic model_grant(int w);
        m_busy = 1; m_cpu = w; m_mm = mm_of(w); m_left = len_of(w);
        m_ptr  = (w + 1) % 4;
    endtask

    task automatic model_step();
        logic [3:0] e;
        int w;
        for (int i = 0; i < 4; i++) e[i] = bus.cpu_req[i] & bus.mm_enable[mm_of(i)];
        if (!m_busy) begin
            w = pick(e, m_ptr);
            if (w >= 0) model_grant(w);
        end else if (!bus.cpu_req[m_cpu] || !bus.mm_enable[m_mm]) begin
            m_busy = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            w = pick(e, m_ptr);
            if (w >= 0) model_grant(w);
            else m_busy = 0;
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [3:0] g;
        logic [7:0] s;
        g = m_busy ? 4'(1 << m_cpu) : 4'h0;
        s = 8'h0;
        if (m_busy) s[2*m_mm +: 2] = 2'(m_cpu);
        return {g, m_busy, m_busy, 4'(m_left), 2'(m_mm), s};
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {bus.cpu_gnt, bus.xbar_valid, bus.busy, bus.beat_left, bus.xbar_scheduler,
                bus.xbar_select_3, bus.xbar_select_2, bus.xbar_select_1, bus.xbar_select_0};
    endfunction

    function automatic logic [1:0] sel_of(int m);
        case (m)
            0: return bus.xbar_select_0;
            1: return bus.xbar_select_1;
            2: return bus.xbar_select_2;
            default: return bus.xbar_select_3;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // compare the DUT outputs 1 time unit after the edge.
    task automatic step();
        logic [W-1:0] e, a;
        if (rst_n) model_step();
        else model_reset();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = dut_out();
        if (!e[W-5]) begin
            // route fields are don't-care while no burst is active
            e[9:0] = '0;
            a[9:0] = '0;
        end
        check("scoreboard", 32'(a), 32'(e));
        check("state_o", 32'(state_o == BURST), 32'(e[W-6]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(logic [3:0] req, logic [7:0] mm, logic [15:0] len, logic [3:0] en);
        bus.cpu_req   = req;
        bus.cpu_mm    = mm;
        bus.cpu_len   = len;
        bus.mm_enable = en;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(4'h0, 8'h00, 16'h0000, 4'hF);
        @(posedge clk);
        #1;
        check("reset_outputs", 32'(dut_out()), 32'h0);
        check("reset_state", 32'(state_o == IDLE), 32'h1);
        model_reset();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]  req;
        logic [7:0]  mm;
        logic [15:0] len;
        logic [3:0]  en;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_sched;
        logic [1:0]  exp_cpu;
        int          exp_beats;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int beats, guard;
        logic [3:0] rr_exp[5];

        rst_n = 1'b0;
        drive(4'h0, 8'h00, 16'h0000, 4'hF);

        vecs[0] = '{4'b0001, 8'h02, 16'h0003, 4'hF, 4'b0001, 2'd2, 2'd0, 4};
        vecs[1] = '{4'b0110, 8'h0C, 16'h0500, 4'hF, 4'b0010, 2'd3, 2'd1, 1};
        vecs[2] = '{4'b1100, 8'h60, 16'hF000, 4'hB, 4'b1000, 2'd1, 2'd3, 16};
        vecs[3] = '{4'b1111, 8'h00, 16'h0001, 4'h1, 4'b0001, 2'd0, 2'd0, 2};
        vecs[4] = '{4'b1010, 8'h84, 16'h0070, 4'hF, 4'b0010, 2'd1, 2'd1, 8};

        for (int v = 0; v < 5; v++) begin
            reset_dut();
            drive(vecs[v].req, vecs[v].mm, vecs[v].len, vecs[v].en);
            step();
            check("vec_gnt", 32'(bus.cpu_gnt), 32'(vecs[v].exp_gnt));
            check("vec_sched", 32'(bus.xbar_scheduler), 32'(vecs[v].exp_sched));
            check("vec_select", 32'(sel_of(int'(vecs[v].exp_sched))), 32'(vecs[v].exp_cpu));
            beats = 1;
            guard = 0;
            while (m_busy && m_left != 0 && guard < 40) begin
                step();
                beats++;
                guard++;
            end
            check("vec_beats", 32'(beats), 32'(vecs[v].exp_beats));
            bus.cpu_req = 4'h0;
            step();
            check("vec_idle_after", 32'({bus.cpu_gnt, bus.xbar_valid, bus.busy}), 32'h0);
        end

        // Round-robin with all CPUs requesting single-beat bursts.
        reset_dut();
        drive(4'hF, 8'hE4, 16'h0000, 4'hF);
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_gnt", 32'(bus.cpu_gnt), 32'(rr_exp[k]));
            check("rr_valid", 32'(bus.xbar_valid), 32'h1);
        end
        bus.cpu_req = 4'h0;
        step();

        // Abort: CPU2 drops its request after two beats.
        reset_dut();
        drive(4'b0100, 8'h10, 16'h0700, 4'hF);
        step();
        check("abort_gnt", 32'(bus.cpu_gnt), 32'h4);
        step();
        check("abort_beat2", 32'(bus.beat_left), 32'h6);
        bus.cpu_req = 4'h0;
        step();
        check("abort_idle", 32'({bus.cpu_gnt, bus.xbar_valid, bus.busy, bus.beat_left}), 32'h0);
        drive(4'hF, 8'hE4, 16'h0000, 4'hF);
        step();
        check("abort_next_gnt", 32'(bus.cpu_gnt), 32'h8);
        bus.cpu_req = 4'h0;
        step();

        // MM disable: CPU1 targets disabled MM3 until the enable rises.
        reset_dut();
        drive(4'b0011, 8'h0D, 16'h0002, 4'b0111);
        step();
        check("mmdis_gnt0", 32'(bus.cpu_gnt), 32'h1);
        check("mmdis_sched0", 32'(bus.xbar_scheduler), 32'h1);
        step();
        check("mmdis_hold", 32'(bus.cpu_gnt), 32'h1);
        bus.mm_enable = 4'hF;
        step();
        check("mmdis_last", 32'(bus.cpu_gnt), 32'h1);
        step();
        check("mmdis_gnt1", 32'(bus.cpu_gnt), 32'h2);
        check("mmdis_sched1", 32'(bus.xbar_scheduler), 32'h3);
        check("mmdis_sel3", 32'(bus.xbar_select_3), 32'h1);
        bus.cpu_req = 4'h0;
        step();

        // Asynchronous reset in the middle of a burst.
        reset_dut();
        drive(4'b0001, 8'h00, 16'h000F, 4'hF);
        step();
        step();
        check("areset_pre_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("areset_outputs", 32'(dut_out()), 32'h0);
        check("areset_state", 32'(state_o == IDLE), 32'h1);
        model_reset();
        #2;
        drive(4'b1000, 8'h40, 16'h0000, 4'hF);
        rst_n = 1'b1;
        step();
        check("areset_gnt3", 32'(bus.cpu_gnt), 32'h8);
        bus.cpu_req = 4'h0;
        step();

        // mm/len changes mid-burst are ignored.
        reset_dut();
        drive(4'b0010, 8'h08, 16'h0040, 4'hF);
        step();
        check("samp_sched", 32'(bus.xbar_scheduler), 32'h2);
        check("samp_sel2", 32'(bus.xbar_select_2), 32'h1);
        bus.cpu_mm  = 8'h00;
        bus.cpu_len = 16'h0010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("samp_beat", 32'(bus.beat_left), 32'(3 - k));
            check("samp_sched_hold", 32'(bus.xbar_scheduler), 32'h2);
            check("samp_sel_hold", 32'(bus.xbar_select_2), 32'h1);
        end
        bus.cpu_req = 4'h0;
        step();

        // Randomized traffic against the model.
        reset_dut();
        drive(4'hF, 8'($urandom), 16'($urandom), 4'hF);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 7) == 0) bus.cpu_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0)
                bus.mm_enable = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            if ($urandom_range(0, 3) == 0) bus.cpu_mm = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                bus.cpu_len = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                         : {4{4'($urandom_range(0, 2))}};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
